// File: rtl/fir_seq_ctrl_pkg.sv
// Shared types, defaults and address helpers for the FIR sequencer.
package fir_ctrl_pkg;

   typedef enum logic [2:0] {
      FLUSH = 3'd0,
      IDLE  = 3'd1,
      MAC   = 3'd2,
      DRAIN = 3'd3,
      CAP   = 3'd4,
      HOLD  = 3'd5
   } state_t;

   localparam int NTAPS_DEF   = 8;
   localparam int MAC_LAT_DEF = 2;

   // Circular decrement (a - k) mod n for a, k < n, correct for any n,
   // not only powers of two.
   function automatic int unsigned addr_wrap_dec(input int unsigned a,
                                                 input int unsigned k,
                                                 input int unsigned n);
      return (a >= k) ? (a - k) : (a + n - k);
   endfunction

endpackage

// File: rtl/fir_seq_ctrl_if.sv
// Handshake and datapath-control bundle between the sequencer and its neighbours.
interface fir_seq_ctrl_if #(parameter int AW = 3);

   logic          s_valid;
   logic          s_ready;
   logic          flush;
   logic          wr_en;
   logic          wr_zero;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;
   logic [AW-1:0] coef_addr;
   logic          mac_clr;
   logic          mac_en;
   logic          acc_cap;
   logic          y_valid;
   logic          y_ready;
   logic          busy;

   modport master (
      input  s_valid, flush, y_ready,
      output s_ready, wr_en, wr_zero, wr_addr, rd_addr, coef_addr,
             mac_clr, mac_en, acc_cap, y_valid, busy
   );

   modport slave (
      output s_valid, flush, y_ready,
      input  s_ready, wr_en, wr_zero, wr_addr, rd_addr, coef_addr,
             mac_clr, mac_en, acc_cap, y_valid, busy
   );

endinterface

// File: rtl/fir_seq_ctrl_counter.sv
// Modulo-N counter with synchronous clear and increment; wraps N-1 to 0.
module mod_counter #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q,
   output logic         last
);

   assign last = (q == W'(N - 1));

   // Clear has priority over increment; increment at the top value wraps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= '0;
      else if (clr)
         q <= '0;
      else if (inc)
         q <= last ? '0 : q + 1'b1;
   end

endmodule

// File: rtl/fir_seq_ctrl.sv
// Sequencer for a time-multiplexed single-MAC FIR: zero-fills the delay line,
// writes incoming samples, steps the MAC over all taps and hands out the result.
module fir_seq_ctrl
   import fir_ctrl_pkg::*;
#(
   parameter int NTAPS   = NTAPS_DEF,
   parameter int AW      = 3,
   parameter int MAC_LAT = MAC_LAT_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   fir_seq_ctrl_if.master       bus
);

   localparam int DCW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

   state_t          state, state_nxt;
   logic [AW-1:0]   wr_ptr, tap, cur;
   logic [DCW-1:0]  dcnt;
   logic            ptr_clr, ptr_inc, ptr_last;
   logic            tap_clr, tap_inc, tap_last;
   logic            cur_load;

   mod_counter #(.N(NTAPS), .W(AW)) u_wr_ptr (
      .clk  (clk),
      .rst  (rst),
      .clr  (ptr_clr),
      .inc  (ptr_inc),
      .q    (wr_ptr),
      .last (ptr_last)
   );

   mod_counter #(.N(NTAPS), .W(AW)) u_tap (
      .clk  (clk),
      .rst  (rst),
      .clr  (tap_clr),
      .inc  (tap_inc),
      .q    (tap),
      .last (tap_last)
   );

   // State register; reset lands in FLUSH so the history is zeroed on release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= FLUSH;
      else
         state <= state_nxt;
   end

   // Remember where the current sample was written; MAC reads walk back from it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cur <= '0;
      else if (cur_load)
         cur <= wr_ptr;
   end

   // Counts cycles spent waiting for the MAC pipeline to empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         dcnt <= '0;
      else if (state == DRAIN)
         dcnt <= dcnt + 1'b1;
      else
         dcnt <= '0;
   end

   // Next-state and strobe decode; everything is forced low while reset is held.
   always_comb begin
      state_nxt     = state;
      ptr_clr       = 1'b0;
      ptr_inc       = 1'b0;
      tap_clr       = 1'b0;
      tap_inc       = 1'b0;
      cur_load      = 1'b0;
      bus.s_ready   = 1'b0;
      bus.wr_en     = 1'b0;
      bus.wr_zero   = 1'b0;
      bus.wr_addr   = wr_ptr;
      bus.rd_addr   = cur;
      bus.coef_addr = '0;
      bus.mac_clr   = 1'b0;
      bus.mac_en    = 1'b0;
      bus.acc_cap   = 1'b0;
      bus.y_valid   = 1'b0;
      bus.busy      = (state != IDLE);

      unique case (state)
         FLUSH: begin
            bus.wr_en   = 1'b1;
            bus.wr_zero = 1'b1;
            bus.wr_addr = tap;
            tap_inc     = 1'b1;
            if (tap_last) begin
               ptr_clr   = 1'b1;
               state_nxt = IDLE;
            end
         end
         IDLE: begin
            bus.s_ready = ~bus.flush;
            if (bus.flush) begin
               tap_clr   = 1'b1;
               state_nxt = FLUSH;
            end else if (bus.s_valid) begin
               bus.wr_en = 1'b1;
               cur_load  = 1'b1;
               ptr_inc   = 1'b1;
               tap_clr   = 1'b1;
               state_nxt = MAC;
            end
         end
         MAC: begin
            bus.mac_en    = 1'b1;
            bus.mac_clr   = (tap == '0);
            bus.coef_addr = tap;
            bus.rd_addr   = AW'(addr_wrap_dec(32'(cur), 32'(tap), NTAPS));
            tap_inc       = 1'b1;
            if (tap_last)
               state_nxt = (MAC_LAT > 0) ? DRAIN : CAP;
         end
         DRAIN: begin
            if (dcnt == DCW'(MAC_LAT - 1))
               state_nxt = CAP;
         end
         CAP: begin
            bus.acc_cap = 1'b1;
            state_nxt   = HOLD;
         end
         HOLD: begin
            bus.y_valid = 1'b1;
            if (bus.y_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = FLUSH;
      endcase

      if (rst) begin
         bus.s_ready   = 1'b0;
         bus.wr_en     = 1'b0;
         bus.wr_zero   = 1'b0;
         bus.wr_addr   = '0;
         bus.rd_addr   = '0;
         bus.coef_addr = '0;
         bus.mac_clr   = 1'b0;
         bus.mac_en    = 1'b0;
         bus.acc_cap   = 1'b0;
         bus.y_valid   = 1'b0;
         bus.busy      = 1'b0;
      end
   end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl with NTAPS=8, MAC_LAT=2.
module tb_fir_seq_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   int   exp_ptr = 0;

   fir_seq_ctrl_if #(.AW(3)) bus();

   fir_seq_ctrl #(.NTAPS(8), .AW(3), .MAC_LAT(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Packs every controller output so reset can be checked in one compare.
   function automatic logic [16:0] all_outs();
      return {bus.s_ready, bus.wr_en, bus.wr_zero, bus.wr_addr, bus.rd_addr,
              bus.coef_addr, bus.mac_clr, bus.mac_en, bus.acc_cap,
              bus.y_valid, bus.busy};
   endfunction

   task test_reset();
      rst = 1'b1;
      bus.s_valid = 1'b0;
      bus.flush   = 1'b0;
      bus.y_ready = 1'b0;
      #3;
      n_cmp++;
      if (all_outs() !== 17'h0) begin
         n_err++; $display("[TB] FAIL reset_outs: got %h want 0", all_outs());
      end
      @(posedge clk); #1;
      n_cmp++;
      if (all_outs() !== 17'h0) begin
         n_err++; $display("[TB] FAIL reset_outs_clk: got %h want 0", all_outs());
      end
      @(negedge clk); rst = 1'b0; #1;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) begin @(negedge clk); #1; end
         n_cmp++;
         if (bus.wr_en !== 1'b1 || bus.wr_zero !== 1'b1 || bus.wr_addr !== 3'(i) ||
             bus.mac_en !== 1'b0 || bus.busy !== 1'b1 || bus.s_ready !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL flush_step%0d: we=%b wz=%b wa=%0d mac=%b busy=%b rdy=%b want 1 1 %0d 0 1 0",
                     i, bus.wr_en, bus.wr_zero, bus.wr_addr, bus.mac_en, bus.busy, bus.s_ready, i);
         end
      end
      @(negedge clk); #1;
      n_cmp++;
      if (bus.s_ready !== 1'b1 || bus.busy !== 1'b0 || bus.wr_en !== 1'b0) begin
         n_err++;
         $display("[TB] FAIL idle_after_flush: rdy=%b busy=%b we=%b want 1 0 0",
                  bus.s_ready, bus.busy, bus.wr_en);
      end
      exp_ptr = 0;
   endtask

   task test_single_sample();
      int cur;
      @(negedge clk); bus.s_valid = 1'b1; #1;
      n_cmp++;
      if (bus.s_ready !== 1'b1 || bus.wr_en !== 1'b1 || bus.wr_zero !== 1'b0 ||
          bus.wr_addr !== 3'(exp_ptr)) begin
         n_err++;
         $display("[TB] FAIL single_accept: rdy=%b we=%b wz=%b wa=%0d want 1 1 0 %0d",
                  bus.s_ready, bus.wr_en, bus.wr_zero, bus.wr_addr, exp_ptr);
      end
      cur = exp_ptr;
      exp_ptr = (exp_ptr + 1) % 8;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk); bus.s_valid = 1'b0; #1;
         n_cmp++;
         if (k <= 8) begin
            if (bus.mac_en !== 1'b1 || bus.mac_clr !== (k == 1) || bus.coef_addr !== 3'(k - 1) ||
                bus.rd_addr !== 3'((cur - (k - 1) + 8) % 8) || bus.wr_en !== 1'b0) begin
               n_err++;
               $display("[TB] FAIL single_mac%0d: en=%b clr=%b ca=%0d ra=%0d we=%b want 1 %b %0d %0d 0",
                        k, bus.mac_en, bus.mac_clr, bus.coef_addr, bus.rd_addr, bus.wr_en,
                        (k == 1), k - 1, (cur - (k - 1) + 8) % 8);
            end
         end else if (k <= 10) begin
            if (bus.mac_en !== 1'b0 || bus.acc_cap !== 1'b0 || bus.y_valid !== 1'b0 || bus.busy !== 1'b1) begin
               n_err++;
               $display("[TB] FAIL single_drain%0d: en=%b cap=%b yv=%b busy=%b want 0 0 0 1",
                        k, bus.mac_en, bus.acc_cap, bus.y_valid, bus.busy);
            end
         end else if (k == 11) begin
            if (bus.acc_cap !== 1'b1 || bus.y_valid !== 1'b0) begin
               n_err++;
               $display("[TB] FAIL single_cap: cap=%b yv=%b want 1 0", bus.acc_cap, bus.y_valid);
            end
         end else begin
            if (bus.y_valid !== 1'b1 || bus.s_ready !== 1'b0 || bus.acc_cap !== 1'b0) begin
               n_err++;
               $display("[TB] FAIL single_hold: yv=%b rdy=%b cap=%b want 1 0 0",
                        bus.y_valid, bus.s_ready, bus.acc_cap);
            end
            bus.y_ready = 1'b1;
         end
      end
      @(negedge clk); bus.y_ready = 1'b0; #1;
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.y_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
         n_err++;
         $display("[TB] FAIL single_idle: busy=%b yv=%b rdy=%b want 0 0 1",
                  bus.busy, bus.y_valid, bus.s_ready);
      end
   endtask

   task test_back_to_back();
      int  acc, last_c, c9, cur9;
      bit  done;
      acc = 0; last_c = -1; c9 = -1; cur9 = 0; done = 1'b0;
      bus.y_ready = 1'b1;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk); bus.s_valid = (acc < 9); #1;
         if (acc == 9 && c > c9 && c <= c9 + 8) begin
            n_cmp++;
            if (bus.rd_addr !== 3'((cur9 - (c - c9 - 1) + 8) % 8)) begin
               n_err++;
               $display("[TB] FAIL b2b_rd%0d: got %0d want %0d", c - c9 - 1, bus.rd_addr,
                        (cur9 - (c - c9 - 1) + 8) % 8);
            end
         end
         if (acc == 9 && c == c9 + 13) begin
            n_cmp++;
            if (bus.busy !== 1'b0 || bus.y_valid !== 1'b0) begin
               n_err++;
               $display("[TB] FAIL b2b_end: busy=%b yv=%b want 0 0", bus.busy, bus.y_valid);
            end
            done = 1'b1;
         end else if (bus.s_valid && bus.s_ready) begin
            n_cmp++;
            if (bus.wr_en !== 1'b1 || bus.wr_addr !== 3'(exp_ptr)) begin
               n_err++;
               $display("[TB] FAIL b2b_wr%0d: we=%b wa=%0d want 1 %0d", acc, bus.wr_en, bus.wr_addr, exp_ptr);
            end
            if (last_c >= 0) begin
               n_cmp++;
               if (c - last_c != 13) begin
                  n_err++;
                  $display("[TB] FAIL b2b_period%0d: got %0d want 13", acc, c - last_c);
               end
            end
            last_c = c;
            acc++;
            if (acc == 9) begin c9 = c; cur9 = exp_ptr; end
            exp_ptr = (exp_ptr + 1) % 8;
         end
      end
      n_cmp++;
      if (!done) begin
         n_err++;
         $display("[TB] FAIL b2b_timeout: accepted %0d want 9", acc);
      end
      bus.s_valid = 1'b0;
      bus.y_ready = 1'b0;
   endtask

   task test_hold();
      int lat;
      @(negedge clk); bus.s_valid = 1'b1; #1;
      n_cmp++;
      if (bus.wr_en !== 1'b1 || bus.wr_addr !== 3'(exp_ptr)) begin
         n_err++;
         $display("[TB] FAIL hold_accept: we=%b wa=%0d want 1 %0d", bus.wr_en, bus.wr_addr, exp_ptr);
      end
      exp_ptr = (exp_ptr + 1) % 8;
      lat = 0;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
         @(negedge clk); bus.s_valid = 1'b0; #1;
         if (bus.y_valid === 1'b1) lat = k;
      end
      n_cmp++;
      if (lat != 12) begin
         n_err++;
         $display("[TB] FAIL hold_latency: got %0d want 12", lat);
      end
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         bus.s_valid = 1'b1;
         bus.flush   = k[0];
         #1;
         n_cmp++;
         if (bus.y_valid !== 1'b1 || bus.s_ready !== 1'b0 || bus.wr_en !== 1'b0 || bus.busy !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL hold_stall%0d: yv=%b rdy=%b we=%b busy=%b want 1 0 0 1",
                     k, bus.y_valid, bus.s_ready, bus.wr_en, bus.busy);
         end
      end
      @(negedge clk); bus.s_valid = 1'b0; bus.flush = 1'b0; bus.y_ready = 1'b1; #1;
      n_cmp++;
      if (bus.y_valid !== 1'b1) begin
         n_err++;
         $display("[TB] FAIL hold_release: yv=%b want 1", bus.y_valid);
      end
      @(negedge clk); bus.y_ready = 1'b0; #1;
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.y_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
         n_err++;
         $display("[TB] FAIL hold_idle: busy=%b yv=%b rdy=%b want 0 0 1",
                  bus.busy, bus.y_valid, bus.s_ready);
      end
   endtask

   task test_flush_priority();
      int k;
      @(negedge clk); bus.s_valid = 1'b1; bus.flush = 1'b1; #1;
      n_cmp++;
      if (bus.s_ready !== 1'b0 || bus.wr_en !== 1'b0) begin
         n_err++;
         $display("[TB] FAIL flushreq_idle: rdy=%b we=%b want 0 0", bus.s_ready, bus.wr_en);
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); bus.s_valid = 1'b0; bus.flush = 1'b0; #1;
         n_cmp++;
         if (bus.wr_en !== 1'b1 || bus.wr_zero !== 1'b1 || bus.wr_addr !== 3'(i)) begin
            n_err++;
            $display("[TB] FAIL flushreq_step%0d: we=%b wz=%b wa=%0d want 1 1 %0d",
                     i, bus.wr_en, bus.wr_zero, bus.wr_addr, i);
         end
      end
      exp_ptr = 0;
      @(negedge clk); bus.s_valid = 1'b1; #1;
      n_cmp++;
      if (bus.s_ready !== 1'b1 || bus.wr_en !== 1'b1 || bus.wr_zero !== 1'b0 || bus.wr_addr !== 3'd0) begin
         n_err++;
         $display("[TB] FAIL flushreq_next: rdy=%b we=%b wz=%b wa=%0d want 1 1 0 0",
                  bus.s_ready, bus.wr_en, bus.wr_zero, bus.wr_addr);
      end
      exp_ptr = 1;
      bus.y_ready = 1'b1;
      k = 0;
      do begin
         @(negedge clk); bus.s_valid = 1'b0; #1;
         k++;
      end while (bus.busy === 1'b1 && k < 30);
      n_cmp++;
      if (k != 13) begin
         n_err++;
         $display("[TB] FAIL flushreq_done: idle after %0d want 13", k);
      end
      bus.y_ready = 1'b0;
   endtask

   task test_reset_mid_op();
      int lat;
      @(negedge clk); bus.s_valid = 1'b1; #1;
      exp_ptr = (exp_ptr + 1) % 8;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk); bus.s_valid = 1'b0; #1;
      end
      n_cmp++;
      if (bus.mac_en !== 1'b1 || bus.coef_addr !== 3'd4) begin
         n_err++;
         $display("[TB] FAIL midrst_tap4: en=%b ca=%0d want 1 4", bus.mac_en, bus.coef_addr);
      end
      #1; rst = 1'b1; #1;
      n_cmp++;
      if (all_outs() !== 17'h0) begin
         n_err++; $display("[TB] FAIL midrst_async: got %h want 0", all_outs());
      end
      @(posedge clk); #1;
      n_cmp++;
      if (all_outs() !== 17'h0) begin
         n_err++; $display("[TB] FAIL midrst_held: got %h want 0", all_outs());
      end
      @(negedge clk); rst = 1'b0; #1;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) begin @(negedge clk); #1; end
         n_cmp++;
         if (bus.wr_en !== 1'b1 || bus.wr_zero !== 1'b1 || bus.wr_addr !== 3'(i) || bus.y_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL midrst_flush%0d: we=%b wz=%b wa=%0d yv=%b want 1 1 %0d 0",
                     i, bus.wr_en, bus.wr_zero, bus.wr_addr, bus.y_valid, i);
         end
      end
      @(negedge clk); #1;
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.y_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
         n_err++;
         $display("[TB] FAIL midrst_idle: busy=%b yv=%b rdy=%b want 0 0 1",
                  bus.busy, bus.y_valid, bus.s_ready);
      end
      exp_ptr = 0;
      @(negedge clk); bus.s_valid = 1'b1; #1;
      n_cmp++;
      if (bus.wr_en !== 1'b1 || bus.wr_addr !== 3'(exp_ptr)) begin
         n_err++;
         $display("[TB] FAIL midrst_accept: we=%b wa=%0d want 1 0", bus.wr_en, bus.wr_addr);
      end
      exp_ptr = 1;
      lat = 0;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
         @(negedge clk); bus.s_valid = 1'b0; #1;
         if (bus.y_valid === 1'b1) lat = k;
      end
      n_cmp++;
      if (lat != 12) begin
         n_err++;
         $display("[TB] FAIL midrst_latency: got %0d want 12", lat);
      end
      bus.y_ready = 1'b1;
      @(negedge clk); bus.y_ready = 1'b0; #1;
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.y_valid !== 1'b0) begin
         n_err++;
         $display("[TB] FAIL midrst_done: busy=%b yv=%b want 0 0", bus.busy, bus.y_valid);
      end
   endtask

   // Runs each scenario in order and reports the totals.
   initial begin
      test_reset();
      test_single_sample();
      test_back_to_back();
      test_hold();
      test_flush_priority();
      test_reset_mid_op();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
